bp_be_nonsynth_slot_tracker: RTL and testbench

Non-synthesizable backend monitor that tracks every pipeline slot from issue to commit and classifies each slot at the commit point. It sits directly upstream of the per-core performance counter block and produces that block's per-cycle inputs: fe_nop, be_nop, me_nop, poison, roll and instr_cmt. Exactly one classification output is asserted each cycle. Bubbles and squashes are attributed to the cycle in which the slot actually reaches commit, not the cycle in which they were caused.

---
 rtl/bp_be_pkg.sv | 45 ++++
 rtl/bp_be_nonsynth_slot_stage.sv | 55 +++++
 rtl/bp_be_nonsynth_slot_tracker.sv | 121 ++++++++++++
 tb/tb_bp_be_nonsynth_slot_tracker.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/bp_be_pkg.sv
// Backend package: the slot classification enum and its helpers used by the
// slot tracker. The slot record itself depends on the PC width, so it is
// declared through the BP_BE_DECLARE_SLOT_S macro below. Each module that
// needs the record expands that macro with its own vaddr_width_p.
//
// Contents:
//   bp_be_slot_class_e  : what a pipeline slot holds (3 bits)
//   slot_class_width_gp : width of the class field, used to size slot ports
//   bp_be_kill_class    : class a slot takes when poison/roll hits it
//   BP_BE_DECLARE_SLOT_S: macro declaring bp_be_slot_s {slot_class, pc}
package bp_be_pkg;

    localparam int slot_class_width_gp = 3;

    typedef enum logic [slot_class_width_gp-1:0] {
        e_slot_instr  = 3'd0,
        e_slot_fe_nop = 3'd1,
        e_slot_be_nop = 3'd2,
        e_slot_poison = 3'd3,
        e_slot_roll   = 3'd4
    } bp_be_slot_class_e;

    // Roll is the stronger kill. Once a slot is marked ROLL, a later poison
    // must not demote it. Bubbles are re-marked like real instructions.
    function automatic bp_be_slot_class_e bp_be_kill_class(
        input bp_be_slot_class_e cls,
        input logic              poison,
        input logic              roll
    );
        if (roll) begin
            return e_slot_roll;
        end
        if (poison && (cls != e_slot_roll)) begin
            return e_slot_poison;
        end
        return cls;
    endfunction

endpackage

`define BP_BE_DECLARE_SLOT_S(vaddr_width_mp) \
    typedef struct packed { \
        bp_be_slot_class_e           slot_class; \
        logic [vaddr_width_mp-1:0]   pc; \
    } bp_be_slot_s

// File: rtl/bp_be_nonsynth_slot_stage.sv
// One stage register of the slot tracker pipe. It holds a single
// {slot_class, pc} record.
//
// Ports:
//   clk         : clock
//   reset_n     : asynchronous active-low reset; clears the stage to FE_NOP, pc=0
//   hold        : stage keeps its own (possibly kill-marked) value
//   poison      : mark this stage POISON unless it is already ROLL
//   roll        : mark this stage ROLL
//   next_slot   : value loaded when not holding (upstream's marked value)
//   slot        : registered stage contents, before any kill this cycle
//   marked_slot : stage contents with this cycle's kill marks applied
module bp_be_nonsynth_slot_stage
    import bp_be_pkg::*;
#(
    parameter int vaddr_width_p = 39
)
(
    input  logic                                        clk,
    input  logic                                        reset_n,
    input  logic                                        hold,
    input  logic                                        poison,
    input  logic                                        roll,
    input  logic [slot_class_width_gp+vaddr_width_p-1:0] next_slot,
    output logic [slot_class_width_gp+vaddr_width_p-1:0] slot,
    output logic [slot_class_width_gp+vaddr_width_p-1:0] marked_slot
);

    `BP_BE_DECLARE_SLOT_S(vaddr_width_p);

    bp_be_slot_s current;
    bp_be_slot_s killed;

    // Kill marks apply to the value before the shift. The marked copy is
    // what moves downstream or, when holding, what is written back in place.
    always_comb begin
        killed            = current;
        killed.slot_class = bp_be_kill_class(current.slot_class, poison, roll);
    end

    // Reset forces an FE bubble so the tracker reports fe_nop right away.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            current <= '{slot_class: e_slot_fe_nop, pc: '0};
        end else if (hold) begin
            current <= killed;
        end else begin
            current <= bp_be_slot_s'(next_slot);
        end
    end

    assign slot        = current;
    assign marked_slot = killed;

endmodule

// File: rtl/bp_be_nonsynth_slot_tracker.sv
// Backend slot tracker. It follows every pipeline slot from issue (stage 0)
// to commit (stage pipe_depth_p-1). At commit it classifies the slot for the
// performance counters, so exactly one of the classification outputs is
// high each cycle. A bubble or squash is counted in the cycle its slot
// reaches commit.
//
// Ports:
//   clk_i       : clock
//   reset_n_i   : asynchronous active-low reset
//   fe_v_i      : FE presents an instruction at issue
//   be_hazard_i : BE refuses issue; a BE bubble enters instead
//   issue_pc_i  : PC of the issuing instruction
//   stall_i     : memory hold; pipe does not advance, stage-0 entry dropped
//   poison_i    : kill all in-flight slots (exception/redirect)
//   roll_i      : kill all in-flight slots as rollback replay
//   fe_nop_o, be_nop_o, me_nop_o, poison_o, roll_o, instr_cmt_o : one-hot class
//   cmt_pc_o    : PC of committing slot (0 for bubbles and during stall)
module bp_be_nonsynth_slot_tracker
    import bp_be_pkg::*;
#(
    parameter int pipe_depth_p  = 5,
    parameter int vaddr_width_p = 39
)
(
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     fe_v_i,
    input  logic                     be_hazard_i,
    input  logic [vaddr_width_p-1:0] issue_pc_i,
    input  logic                     stall_i,
    input  logic                     poison_i,
    input  logic                     roll_i,
    output logic                     fe_nop_o,
    output logic                     be_nop_o,
    output logic                     me_nop_o,
    output logic                     poison_o,
    output logic                     roll_o,
    output logic                     instr_cmt_o,
    output logic [vaddr_width_p-1:0] cmt_pc_o
);

    `BP_BE_DECLARE_SLOT_S(vaddr_width_p);

    localparam int slot_width_lp = slot_class_width_gp + vaddr_width_p;

    bp_be_slot_s              entry;
    bp_be_slot_s              commit;
    logic [slot_width_lp-1:0] stage_slot   [pipe_depth_p];
    logic [slot_width_lp-1:0] stage_marked [pipe_depth_p];

    // Stage-0 entry: a BE hazard wins over a missing FE instruction.
    // Bubbles always carry pc=0.
    always_comb begin
        entry = '{slot_class: e_slot_fe_nop, pc: '0};
        if (be_hazard_i) begin
            entry = '{slot_class: e_slot_be_nop, pc: '0};
        end else if (fe_v_i) begin
            entry = '{slot_class: e_slot_instr, pc: issue_pc_i};
        end
    end

    // Stage 0 loads the unmarked entry, so a slot issued together with a kill
    // survives. Later stages load their predecessor's kill-marked value.
    for (genvar k = 0; k < pipe_depth_p; k++) begin : stage
        logic [slot_width_lp-1:0] upstream;

        if (k == 0) begin : head
            assign upstream = entry;
        end else begin : body
            assign upstream = stage_marked[k-1];
        end

        bp_be_nonsynth_slot_stage #(
            .vaddr_width_p(vaddr_width_p)
        ) slot_stage (
            .clk         (clk_i),
            .reset_n     (reset_n_i),
            .hold        (stall_i),
            .poison      (poison_i),
            .roll        (roll_i),
            .next_slot   (upstream),
            .slot        (stage_slot[k]),
            .marked_slot (stage_marked[k])
        );
    end

    // Commit has already happened this cycle, so the pre-kill value of the
    // last stage is reported, not its marked copy.
    assign commit = bp_be_slot_s'(stage_slot[pipe_depth_p-1]);

    // A stall blocks commit outright. Otherwise decode the commit class.
    always_comb begin
        fe_nop_o    = 1'b0;
        be_nop_o    = 1'b0;
        me_nop_o    = 1'b0;
        poison_o    = 1'b0;
        roll_o      = 1'b0;
        instr_cmt_o = 1'b0;
        cmt_pc_o    = '0;
        if (stall_i) begin
            me_nop_o = 1'b1;
        end else begin
            cmt_pc_o = commit.pc;
            unique case (commit.slot_class)
                e_slot_instr:  instr_cmt_o = 1'b1;
                e_slot_fe_nop: fe_nop_o    = 1'b1;
                e_slot_be_nop: be_nop_o    = 1'b1;
                e_slot_poison: poison_o    = 1'b1;
                e_slot_roll:   roll_o      = 1'b1;
                default:       fe_nop_o    = 1'b1;
            endcase
        end
    end

    // The downstream counters rely on exactly one classification per cycle.
    one_class_per_cycle: assert property (
        @(posedge clk_i) disable iff (!reset_n_i)
        $onehot({fe_nop_o, be_nop_o, me_nop_o, poison_o, roll_o, instr_cmt_o})
    );

endmodule

// File: tb/tb_bp_be_nonsynth_slot_tracker.sv
// Testbench for bp_be_nonsynth_slot_tracker. The reference model is a queue
// of in-flight slots. The front of the queue is the commit slot and new
// slots are pushed at the back. Directed scenarios come first, then
// randomized traffic.
module tb_bp_be_nonsynth_slot_tracker;

    localparam int DEPTH = 5;
    localparam int VW    = 39;

    localparam int K_INSTR  = 0;
    localparam int K_FE     = 1;
    localparam int K_BE     = 2;
    localparam int K_POISON = 3;
    localparam int K_ROLL   = 4;

    typedef struct {
        int            kind;
        logic [VW-1:0] pc;
    } model_slot_t;

    model_slot_t model_q[$];

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          fe_v = 1'b0;
    logic          be_hazard = 1'b0;
    logic [VW-1:0] issue_pc = '0;
    logic          stall = 1'b0;
    logic          poison = 1'b0;
    logic          roll = 1'b0;
    logic          fe_nop, be_nop, me_nop, poison_out, roll_out, instr_cmt;
    logic [VW-1:0] cmt_pc;

    int checks_total  = 0;
    int checks_passed = 0;

    always #5 clk = ~clk;

    bp_be_nonsynth_slot_tracker #(
        .pipe_depth_p  (DEPTH),
        .vaddr_width_p (VW)
    ) dut (
        .clk_i       (clk),
        .reset_n_i   (reset_n),
        .fe_v_i      (fe_v),
        .be_hazard_i (be_hazard),
        .issue_pc_i  (issue_pc),
        .stall_i     (stall),
        .poison_i    (poison),
        .roll_i      (roll),
        .fe_nop_o    (fe_nop),
        .be_nop_o    (be_nop),
        .me_nop_o    (me_nop),
        .poison_o    (poison_out),
        .roll_o      (roll_out),
        .instr_cmt_o (instr_cmt),
        .cmt_pc_o    (cmt_pc)
    );

    // After reset, every slot in flight is an FE bubble.
    function automatic void modelReset();
        model_q.delete();
        for (int i = 0; i < DEPTH; i++) begin
            model_q.push_back('{kind: K_FE, pc: '0});
        end
    endfunction

    // One clock edge: kills hit every slot in flight. Then, unless stalled,
    // the oldest slot leaves and the new entry joins the back.
    function automatic void modelStep();
        for (int i = 0; i < model_q.size(); i++) begin
            if (roll) begin
                model_q[i].kind = K_ROLL;
            end else if (poison && model_q[i].kind != K_ROLL) begin
                model_q[i].kind = K_POISON;
            end
        end
        if (!stall) begin
            void'(model_q.pop_front());
            if (be_hazard) begin
                model_q.push_back('{kind: K_BE, pc: '0});
            end else if (fe_v) begin
                model_q.push_back('{kind: K_INSTR, pc: issue_pc});
            end else begin
                model_q.push_back('{kind: K_FE, pc: '0});
            end
        end
    endfunction

    // Flags ordered {fe, be, me, poison, roll, instr}.
    task automatic checkOutput(input string tag);
        logic [5:0]    exp_flags;
        logic [VW-1:0] exp_pc;
        logic [5:0]    obs_flags;
        exp_pc = '0;
        if (stall) begin
            exp_flags = 6'b001000;
        end else begin
            exp_pc = model_q[0].pc;
            case (model_q[0].kind)
                K_INSTR:  exp_flags = 6'b000001;
                K_FE:     exp_flags = 6'b100000;
                K_BE:     exp_flags = 6'b010000;
                K_POISON: exp_flags = 6'b000100;
                default:  exp_flags = 6'b000010;
            endcase
        end
        obs_flags = {fe_nop, be_nop, me_nop, poison_out, roll_out, instr_cmt};
        checks_total++;
        assert (obs_flags === exp_flags) checks_passed++;
        else $error("[TB] FAIL %s flags observed=%b expected=%b", tag, obs_flags, exp_flags);
        checks_total++;
        assert (cmt_pc === exp_pc) checks_passed++;
        else $error("[TB] FAIL %s cmt_pc observed=%h expected=%h", tag, cmt_pc, exp_pc);
    endtask

    // Drive one cycle of inputs, check the outputs at the falling edge, then
    // advance the model on the rising edge.
    task automatic applyStimulus(input logic v, input logic hz, input logic [VW-1:0] pc,
                                 input logic st, input logic po, input logic ro,
                                 input string tag);
        fe_v      = v;
        be_hazard = hz;
        issue_pc  = pc;
        stall     = st;
        poison    = po;
        roll      = ro;
        @(negedge clk);
        checkOutput(tag);
        @(posedge clk);
        modelStep();
        #1;
    endtask

    task automatic idleCycles(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, tag);
        end
    endtask

    initial begin
        logic [63:0] rnd;

        $display("[TB] reset");
        #1 reset_n = 1'b0;
        modelReset();
        #1;
        checks_total++;
        assert ({fe_nop, be_nop, me_nop, poison_out, roll_out, instr_cmt, cmt_pc} ===
                {6'b100000, {VW{1'b0}}}) checks_passed++;
        else $error("[TB] FAIL reset_state observed=%b/%h expected=100000/0",
                    {fe_nop, be_nop, me_nop, poison_out, roll_out, instr_cmt}, cmt_pc);
        @(posedge clk);
        @(posedge clk);
        #1 reset_n = 1'b1;

        $display("[TB] idle");
        idleCycles(10, "idle");

        $display("[TB] single instruction");
        applyStimulus(1'b1, 1'b0, 39'h1000, 1'b0, 1'b0, 1'b0, "single_issue");
        idleCycles(6, "single_drain");

        $display("[TB] stall");
        applyStimulus(1'b1, 1'b0, 39'h1000, 1'b0, 1'b0, 1'b0, "stall_c0");
        applyStimulus(1'b1, 1'b0, 39'h1004, 1'b0, 1'b0, 1'b0, "stall_c1");
        applyStimulus(1'b1, 1'b0, 39'h1008, 1'b1, 1'b0, 1'b0, "stall_c2");
        applyStimulus(1'b1, 1'b0, 39'h1008, 1'b0, 1'b0, 1'b0, "stall_c3");
        idleCycles(7, "stall_drain");

        $display("[TB] poison");
        applyStimulus(1'b1, 1'b0, 39'h2000, 1'b0, 1'b0, 1'b0, "poison_c0");
        applyStimulus(1'b1, 1'b0, 39'h2004, 1'b0, 1'b0, 1'b0, "poison_c1");
        applyStimulus(1'b1, 1'b0, 39'h2008, 1'b0, 1'b0, 1'b0, "poison_c2");
        applyStimulus(1'b1, 1'b0, 39'h200c, 1'b0, 1'b1, 1'b0, "poison_c3");
        idleCycles(7, "poison_drain");

        $display("[TB] poison then roll");
        applyStimulus(1'b1, 1'b0, 39'h3000, 1'b0, 1'b0, 1'b0, "roll_c0");
        applyStimulus(1'b1, 1'b0, 39'h3004, 1'b0, 1'b0, 1'b0, "roll_c1");
        applyStimulus(1'b1, 1'b0, 39'h3008, 1'b0, 1'b1, 1'b0, "roll_c2");
        applyStimulus(1'b1, 1'b1, 39'h300c, 1'b0, 1'b0, 1'b1, "roll_c3");
        idleCycles(7, "roll_drain");

        $display("[TB] kill during stall");
        applyStimulus(1'b1, 1'b0, 39'h4000, 1'b0, 1'b0, 1'b0, "kstall_c0");
        applyStimulus(1'b1, 1'b0, 39'h4004, 1'b1, 1'b1, 1'b0, "kstall_c1");
        applyStimulus(1'b1, 1'b0, 39'h4004, 1'b0, 1'b0, 1'b0, "kstall_c2");
        idleCycles(7, "kstall_drain");

        $display("[TB] mid-stream reset");
        applyStimulus(1'b1, 1'b0, 39'h5000, 1'b0, 1'b0, 1'b0, "mrst_c0");
        applyStimulus(1'b1, 1'b0, 39'h5004, 1'b0, 1'b0, 1'b0, "mrst_c1");
        applyStimulus(1'b1, 1'b0, 39'h5008, 1'b0, 1'b0, 1'b0, "mrst_c2");
        applyStimulus(1'b1, 1'b0, 39'h500c, 1'b0, 1'b0, 1'b0, "mrst_c3");
        fe_v = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        checks_total++;
        assert ({fe_nop, be_nop, me_nop, poison_out, roll_out, instr_cmt, cmt_pc} ===
                {6'b100000, {VW{1'b0}}}) checks_passed++;
        else $error("[TB] FAIL midreset_state observed=%b/%h expected=100000/0",
                    {fe_nop, be_nop, me_nop, poison_out, roll_out, instr_cmt}, cmt_pc);
        modelReset();
        @(negedge clk);
        checkOutput("mrst_hold");
        @(posedge clk);
        #1 reset_n = 1'b1;
        idleCycles(8, "mrst_after");

        $display("[TB] random traffic");
        for (int i = 0; i < 300; i++) begin
            rnd = {$urandom, $urandom};
            applyStimulus($urandom_range(0, 3) != 0,
                          $urandom_range(0, 5) == 0,
                          rnd[VW-1:0],
                          $urandom_range(0, 6) == 0,
                          $urandom_range(0, 15) == 0,
                          $urandom_range(0, 19) == 0,
                          "random");
        end
        idleCycles(DEPTH + 1, "random_drain");

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
